// File: rtl/s2mm_packer_pkg.sv
// Shared constants, state encoding and tkeep helper for the S2MM symbol packer.
package s2mm_pkg;

    localparam logic [7:0] K28_5_IDLE = 8'hBC;
    localparam logic [7:0] K29_7_EOF  = 8'hFD;

    localparam int                CNT_W    = 3;
    localparam logic [CNT_W-1:0]  CNT_FULL = 3'd4;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        HELD
    } state_t;

    function automatic logic [3:0] keep_from_cnt(input logic [CNT_W-1:0] cnt);
        logic [3:0] keep;
        keep = 4'h0;
        case (cnt)
            3'd1:    keep = 4'h1;
            3'd2:    keep = 4'h3;
            3'd3:    keep = 4'h7;
            3'd4:    keep = 4'hF;
            default: keep = 4'h0;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/s2mm_packer.sv
// Strips idle commas from the recovered CameraLink symbol stream and packs data bytes into AXI4-Stream words.
// Optional stalled-frame flush is enabled with `define S2MM_TIMEOUT_FLUSH_EN.
//
// state   | meaning
// EMPTY   | cnt=0, accumulator holds no bytes
// PARTIAL | cnt=1..3, word being filled from lane 0 upward
// HELD    | cnt=4, full word kept back until the next symbol says whether it is the last
module s2mm_packer
    import s2mm_pkg::*;
#(
    parameter logic [7:0]  EOF_K   = K29_7_EOF,
    parameter logic [7:0]  IDLE_K  = K28_5_IDLE,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        FIFO_reset,
    input  logic        sym_valid,
    input  logic [7:0]  sym_data,
    input  logic        sym_ctrl,
    output logic        sym_ready,
    output logic [31:0] M_AXIS_S2MM_tdata,
    output logic [3:0]  M_AXIS_S2MM_tkeep,
    output logic        M_AXIS_S2MM_tlast,
    output logic        M_AXIS_S2MM_tvalid,
    input  logic        M_AXIS_S2MM_tready,
    output logic        rx_k_error
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("s2mm_packer: TIMEOUT must be within 2..65535");
    end

    state_t             state;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               take_data, take_eof, take_bad;
    logic               load, load_last;
    logic [3:0]         load_keep;
    logic               timeout_fire;

    always_comb begin
        sym_ready = ~M_AXIS_S2MM_tvalid | M_AXIS_S2MM_tready;
        take_data = sym_valid & sym_ready & ~sym_ctrl;
        take_eof  = sym_valid & sym_ready & sym_ctrl & (sym_data == EOF_K);
        take_bad  = sym_valid & sym_ready & sym_ctrl & (sym_data != EOF_K) & (sym_data != IDLE_K);
        if (cnt_q == '0)
            state = EMPTY;
        else if (cnt_q == CNT_FULL)
            state = HELD;
        else
            state = PARTIAL;
    end

`ifdef S2MM_TIMEOUT_FLUSH_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Saturates at TIMEOUT so a blocked output still flushes once it frees up.
    always_comb begin
        timeout_fire = (state != EMPTY) && (idle_cnt_q == TIMEOUT_W) && sym_ready
                       && !take_data && !take_eof;
        idle_cnt_d = idle_cnt_q;
        if (state == EMPTY || take_data || take_eof || timeout_fire)
            idle_cnt_d = '0;
        else if (idle_cnt_q != TIMEOUT_W)
            idle_cnt_d = idle_cnt_q + 16'd1;
    end

    always_ff @(posedge sys_clk or posedge FIFO_reset) begin
        if (FIFO_reset)
            idle_cnt_q <= '0;
        else
            idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_last = 1'b0;
        load_keep = 4'hF;
        if (take_data) begin
            if (state == HELD) begin
                load  = 1'b1;
                acc_d = {24'h0, sym_data};
                cnt_d = 3'd1;
            end else begin
                acc_d[{cnt_q[1:0], 3'b000} +: 8] = sym_data;
                cnt_d = cnt_q + 3'd1;
            end
        end else if ((take_eof && state != EMPTY) || timeout_fire) begin
            load      = 1'b1;
            load_last = 1'b1;
            load_keep = keep_from_cnt(cnt_q);
            acc_d     = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge FIFO_reset) begin
        if (FIFO_reset) begin
            acc_q              <= '0;
            cnt_q              <= '0;
            M_AXIS_S2MM_tdata  <= '0;
            M_AXIS_S2MM_tkeep  <= '0;
            M_AXIS_S2MM_tlast  <= 1'b0;
            M_AXIS_S2MM_tvalid <= 1'b0;
            rx_k_error         <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (load) begin
                M_AXIS_S2MM_tdata  <= acc_q;
                M_AXIS_S2MM_tkeep  <= load_keep;
                M_AXIS_S2MM_tlast  <= load_last;
                M_AXIS_S2MM_tvalid <= 1'b1;
            end else if (M_AXIS_S2MM_tready) begin
                M_AXIS_S2MM_tvalid <= 1'b0;
            end
            if (take_bad)
                rx_k_error <= 1'b1;
        end
    end

endmodule
